// File: rtl/rv32_pkg.sv
// Shared RV32 sequencer definitions: opcodes, state encoding,
// PC-source and writeback-select encodings.
package rv32_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      PC_PLUS4  = 2'b00,
      PC_BRANCH = 2'b01,
      PC_JALR   = 2'b10
   } pc_src_t;

   typedef enum logic [1:0] {
      WB_ALU = 2'b00,
      WB_MEM = 2'b01,
      WB_PC4 = 2'b10,
      WB_IMM = 2'b11
   } wb_sel_t;

   // True for every opcode this sequencer knows how to run
   function automatic logic op_supported(input logic [6:0] op);
      logic ok;
      ok = 1'b0;
      case (op)
         OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
         OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM: ok = 1'b1;
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Loads allow LB/LH/LW/LBU/LHU; stores allow SB/SH/SW
   function automatic logic ls_funct3_ok(input logic       is_store,
                                         input logic [2:0] f3);
      logic ok;
      if (is_store) begin
         ok = (f3 <= 3'd2);
      end else begin
         ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) ||
              (f3 == 3'd4) || (f3 == 3'd5);
      end
      return ok;
   endfunction

endpackage

// File: rtl/mem_lane_decode.sv
// Byte-lane enables and alignment check for a data access,
// derived from the access width in funct3 and the low address bits.
module mem_lane_decode (
   input  logic [2:0] funct3,
   input  logic [1:0] addr_lo,
   output logic [3:0] be,
   output logic       misaligned
);

   logic [1:0] w_size;

   assign w_size = funct3[1:0];

   // Width 00 byte, 01 half, 10 word; 11 never reaches memory
   always_comb begin
      be         = 4'b0000;
      misaligned = 1'b0;
      unique case (w_size)
         2'b00: begin
            be = 4'b0001 << addr_lo;
         end
         2'b01: begin
            be         = 4'b0011 << addr_lo;
            misaligned = addr_lo[0];
         end
         2'b10: begin
            be         = 4'b1111;
            misaligned = |addr_lo;
         end
         default: begin
            be         = 4'b0000;
            misaligned = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle RV32 control sequencer: fetch, decode, execute,
// memory and writeback control strobes plus retired-instruction count.
module core_sequencer
   import rv32_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [6:0]  opcode,
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic        branch_taken,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic        mem_is_fetch,
   output logic [3:0]  mem_be,
   output logic        ir_we,
   output logic        pc_we,
   output logic        reg_we,
   output logic        alu_a_pc,
   output logic        alu_b_imm,
   output logic [1:0]  pc_src,
   output logic [1:0]  wb_sel,
   output logic [2:0]  state,
   output logic        ecall,
   output logic        halted,
   output logic        illegal,
   output logic        misaligned,
   output logic [31:0] instret
);

   state_t      r_state;
   logic        r_illegal;
   logic        r_misaligned;
   logic [31:0] r_instret;

   logic        w_is_r;
   logic        w_is_load;
   logic        w_is_store;
   logic        w_is_br;
   logic        w_is_jal;
   logic        w_is_jalr;
   logic        w_is_lui;
   logic        w_is_auipc;
   logic        w_is_sys;
   logic        w_is_ls;
   logic        w_ls_bad;
   logic [3:0]  w_be;
   logic        w_lane_mis;

   assign w_is_r     = (opcode == OP_R);
   assign w_is_load  = (opcode == OP_LOAD);
   assign w_is_store = (opcode == OP_STORE);
   assign w_is_br    = (opcode == OP_BRANCH);
   assign w_is_jal   = (opcode == OP_JAL);
   assign w_is_jalr  = (opcode == OP_JALR);
   assign w_is_lui   = (opcode == OP_LUI);
   assign w_is_auipc = (opcode == OP_AUIPC);
   assign w_is_sys   = (opcode == OP_SYSTEM);
   assign w_is_ls    = w_is_load | w_is_store;
   assign w_ls_bad   = w_is_ls & ~ls_funct3_ok(w_is_store, funct3);

   mem_lane_decode u_lane (
      .funct3     (funct3),
      .addr_lo    (addr_lo),
      .be         (w_be),
      .misaligned (w_lane_mis)
   );

   assign state      = r_state;
   assign halted     = (r_state == ST_HALT);
   assign illegal    = r_illegal;
   assign misaligned = r_misaligned;
   assign instret    = r_instret;

   // Sequencer state, sticky fault flags and retire counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= ST_FETCH;
         r_illegal    <= 1'b0;
         r_misaligned <= 1'b0;
         r_instret    <= 32'd0;
      end else begin
         if (pc_we) begin
            r_instret <= r_instret + 32'd1;
         end
         unique case (r_state)
            ST_FETCH: begin
               if (mem_ready) begin
                  r_state <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               if (!op_supported(opcode)) begin
                  r_illegal <= 1'b1;
                  r_state   <= ST_HALT;
               end else begin
                  r_state <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (w_is_ls) begin
                  if (w_ls_bad) begin
                     r_illegal <= 1'b1;
                     r_state   <= ST_HALT;
                  end else if (w_lane_mis) begin
                     r_misaligned <= 1'b1;
                     r_state      <= ST_HALT;
                  end else begin
                     r_state <= ST_MEM;
                  end
               end else if (w_is_sys) begin
                  r_state <= ST_FETCH;
               end else begin
                  r_state <= ST_WB;
               end
            end
            ST_MEM: begin
               if (mem_ready) begin
                  r_state <= w_is_load ? ST_WB : ST_FETCH;
               end
            end
            ST_WB: begin
               r_state <= ST_FETCH;
            end
            ST_HALT: begin
               r_state <= ST_HALT;
            end
            default: begin
               r_state <= ST_FETCH;
            end
         endcase
      end
   end

   // Control strobes decoded from state; all forced low under reset
   always_comb begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_is_fetch = 1'b0;
      mem_be       = 4'b0000;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      reg_we       = 1'b0;
      alu_a_pc     = 1'b0;
      alu_b_imm    = 1'b0;
      pc_src       = PC_PLUS4;
      wb_sel       = WB_ALU;
      ecall        = 1'b0;
      if (!reset) begin
         unique case (r_state)
            ST_FETCH: begin
               mem_req      = 1'b1;
               mem_is_fetch = 1'b1;
               mem_be       = 4'b1111;
               ir_we        = mem_ready;
            end
            ST_EXEC: begin
               alu_b_imm = ~(w_is_r | w_is_br);
               alu_a_pc  = w_is_auipc;
               if (w_is_sys) begin
                  ecall  = 1'b1;
                  pc_we  = 1'b1;
                  pc_src = PC_PLUS4;
               end
            end
            ST_MEM: begin
               mem_req = 1'b1;
               mem_we  = w_is_store;
               mem_be  = w_be;
               if (mem_ready && w_is_store) begin
                  pc_we  = 1'b1;
                  pc_src = PC_PLUS4;
               end
            end
            ST_WB: begin
               pc_we  = 1'b1;
               reg_we = ~w_is_br;
               if (w_is_jal || (w_is_br && branch_taken)) begin
                  pc_src = PC_BRANCH;
               end else if (w_is_jalr) begin
                  pc_src = PC_JALR;
               end
               if (w_is_load) begin
                  wb_sel = WB_MEM;
               end else if (w_is_jal || w_is_jalr) begin
                  wb_sel = WB_PC4;
               end else if (w_is_lui) begin
                  wb_sel = WB_IMM;
               end
            end
            default: begin
               mem_req = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: per-cycle comparison against
// an instruction-level model plus literal latency/field checks.
module tb_core_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [6:0]  opcode = 7'd0;
   logic [2:0]  funct3 = 3'd0;
   logic [1:0]  addr_lo = 2'd0;
   logic        branch_taken = 1'b0;
   logic        mem_ready = 1'b0;
   logic        mem_req, mem_we, mem_is_fetch;
   logic [3:0]  mem_be;
   logic        ir_we, pc_we, reg_we, alu_a_pc, alu_b_imm;
   logic [1:0]  pc_src, wb_sel;
   logic [2:0]  state;
   logic        ecall, halted, illegal, misaligned;
   logic [31:0] instret;

   core_sequencer dut (
      .clk          (clk),
      .reset        (reset),
      .opcode       (opcode),
      .funct3       (funct3),
      .addr_lo      (addr_lo),
      .branch_taken (branch_taken),
      .mem_ready    (mem_ready),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_is_fetch (mem_is_fetch),
      .mem_be       (mem_be),
      .ir_we        (ir_we),
      .pc_we        (pc_we),
      .reg_we       (reg_we),
      .alu_a_pc     (alu_a_pc),
      .alu_b_imm    (alu_b_imm),
      .pc_src       (pc_src),
      .wb_sel       (wb_sel),
      .state        (state),
      .ecall        (ecall),
      .halted       (halted),
      .illegal      (illegal),
      .misaligned   (misaligned),
      .instret      (instret)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]  st;
      logic        req;
      logic        we;
      logic        fetch;
      logic [3:0]  be;
      logic        irwe;
      logic        pcwe;
      logic        regwe;
      logic        apc;
      logic        bimm;
      logic [1:0]  pcsrc;
      logic [1:0]  wbsel;
      logic        ecall;
      logic        halted;
      logic        ill;
      logic        mis;
      logic [31:0] instret;
   } obs_t;

   obs_t exp_r;
   bit   exp_valid = 0;
   int   n_err = 0;
   int   n_chk = 0;
   int   instr_id = 0;
   int   last_id = 0;

   int         ph_cyc, ir_cyc, pc_cyc;
   logic [1:0] pcsrc_seen;
   bit         reg_seen, data_seen, we_seen;
   logic [3:0] be_seen;

   int m_instret = 0;
   bit m_ill = 0;
   bit m_mis = 0;

   function automatic obs_t dut_obs();
      obs_t o;
      o.st = state; o.req = mem_req; o.we = mem_we;
      o.fetch = mem_is_fetch; o.be = mem_be; o.irwe = ir_we;
      o.pcwe = pc_we; o.regwe = reg_we; o.apc = alu_a_pc;
      o.bimm = alu_b_imm; o.pcsrc = pc_src; o.wbsel = wb_sel;
      o.ecall = ecall; o.halted = halted; o.ill = illegal;
      o.mis = misaligned; o.instret = instret;
      return o;
   endfunction

   function automatic obs_t base(input int st);
      obs_t r;
      r = '0;
      r.st = st[2:0];
      r.halted = (st == 5);
      r.ill = m_ill;
      r.mis = m_mis;
      r.instret = m_instret;
      return r;
   endfunction

   // Mid-cycle comparison of every output against the model
   obs_t act;
   always @(negedge clk) begin
      if (exp_valid) begin
         if (instr_id != last_id) begin
            last_id = instr_id;
            ph_cyc = 0; ir_cyc = 0; pc_cyc = 0;
            pcsrc_seen = 2'b00; reg_seen = 0; data_seen = 0;
            we_seen = 0; be_seen = 4'b0000;
         end
         ph_cyc++;
         act = dut_obs();
         n_chk++;
         if (act !== exp_r) begin
            n_err++;
            $display("FAIL cycle id=%0d ph=%0d: got %h want %h",
                     instr_id, ph_cyc, act, exp_r);
         end
         if (ir_we) ir_cyc = ph_cyc;
         if (pc_we) begin
            pc_cyc = ph_cyc;
            pcsrc_seen = pc_src;
         end
         if (reg_we) reg_seen = 1;
         if (mem_req && !mem_is_fetch) begin
            data_seen = 1;
            be_seen = mem_be;
            we_seen = mem_we;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic halt_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         mem_ready = i[0];
         exp_r = base(5);
         tick();
      end
      mem_ready = 0;
   endtask

   task automatic do_reset();
      reset = 1;
      m_instret = 0; m_ill = 0; m_mis = 0;
      exp_r = base(0);
      exp_valid = 1;
      #1;
      chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
      chk("rst_state", {29'd0, state}, 32'd0);
      tick();
      tick();
      reset = 0;
   endtask

   task automatic run(input logic [6:0] op, input logic [2:0] f3,
                      input logic [1:0] al, input bit bt,
                      input int fw, input int mw, input bit noise,
                      input bit rst_mid);
      bit ld, st, br, sup, bad, mis;
      int bytes, mask;
      opcode = op; funct3 = f3; addr_lo = al; branch_taken = bt;
      instr_id++;
      ld = (op == 7'b0000011);
      st = (op == 7'b0100011);
      br = (op == 7'b1100011);
      sup = (op == 7'b0110011) || (op == 7'b0010011) || ld || st ||
            br || (op == 7'b1101111) || (op == 7'b1100111) ||
            (op == 7'b0110111) || (op == 7'b0010111) ||
            (op == 7'b1110011);
      bytes = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      mask = ((1 << bytes) - 1) << al;
      bad = ld ? !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5)
               : (f3 > 2);
      mis = (al % bytes) != 0;
      for (int i = 0; i < fw; i++) begin
         mem_ready = 0;
         exp_r = base(0);
         exp_r.req = 1; exp_r.fetch = 1; exp_r.be = 4'hF;
         exp_valid = 1;
         tick();
      end
      mem_ready = 1;
      exp_r = base(0);
      exp_r.req = 1; exp_r.fetch = 1; exp_r.be = 4'hF; exp_r.irwe = 1;
      exp_valid = 1;
      tick();
      mem_ready = noise;
      exp_r = base(1);
      tick();
      if (!sup) begin
         m_ill = 1;
         halt_cycles(10);
         return;
      end
      exp_r = base(2);
      exp_r.bimm = !((op == 7'b0110011) || br);
      exp_r.apc = (op == 7'b0010111);
      if (op == 7'b1110011) begin
         exp_r.ecall = 1; exp_r.pcwe = 1;
         tick();
         m_instret++;
         mem_ready = 0;
         return;
      end
      tick();
      if (ld || st) begin
         if (bad) begin
            m_ill = 1;
            halt_cycles(10);
            return;
         end
         if (mis) begin
            m_mis = 1;
            halt_cycles(10);
            return;
         end
         for (int i = 0; i < mw; i++) begin
            if (rst_mid && i == 1) begin
               do_reset();
               return;
            end
            mem_ready = 0;
            exp_r = base(3);
            exp_r.req = 1; exp_r.we = st; exp_r.be = mask[3:0];
            tick();
         end
         mem_ready = 1;
         exp_r = base(3);
         exp_r.req = 1; exp_r.we = st; exp_r.be = mask[3:0];
         exp_r.pcwe = st;
         tick();
         mem_ready = 0;
         if (st) begin
            m_instret++;
            return;
         end
      end
      mem_ready = noise;
      exp_r = base(4);
      exp_r.pcwe = 1;
      exp_r.regwe = !br;
      if ((op == 7'b1101111) || (br && bt)) exp_r.pcsrc = 2'b01;
      else if (op == 7'b1100111) exp_r.pcsrc = 2'b10;
      if (ld) exp_r.wbsel = 2'b01;
      else if ((op == 7'b1101111) || (op == 7'b1100111))
         exp_r.wbsel = 2'b10;
      else if (op == 7'b0110111) exp_r.wbsel = 2'b11;
      tick();
      m_instret++;
      mem_ready = 0;
   endtask

   initial begin
      do_reset();
      // addi x10,x10,0x0A5 zero-wait
      run(7'b0010011, 3'b000, 2'd0, 0, 0, 0, 0, 0);
      chk("addi_ir_cyc", ir_cyc, 1);
      chk("addi_pc_cyc", pc_cyc, 4);
      chk("addi_pcsrc", {30'd0, pcsrc_seen}, 0);
      chk("addi_reg_we", {31'd0, reg_seen}, 1);
      chk("addi_instret", instret, 1);
      run(7'b0110011, 3'b000, 2'd0, 0, 1, 0, 1, 0);
      run(7'b0000011, 3'b010, 2'd0, 0, 0, 0, 0, 0);
      chk("lw_pc_cyc", pc_cyc, 5);
      run(7'b0000011, 3'b100, 2'd3, 0, 0, 2, 1, 0);
      chk("lbu_be", {28'd0, be_seen}, 32'h8);
      run(7'b0000011, 3'b101, 2'd2, 0, 2, 1, 0, 0);
      chk("lhu_be", {28'd0, be_seen}, 32'hC);
      // sb with addr_lo=2 and three fetch wait cycles
      run(7'b0100011, 3'b000, 2'd2, 0, 3, 1, 0, 0);
      chk("sb_be", {28'd0, be_seen}, 32'h4);
      chk("sb_we", {31'd0, we_seen}, 1);
      chk("sb_no_reg_we", {31'd0, reg_seen}, 0);
      chk("sb_pc_cyc", pc_cyc, 8);
      run(7'b0100011, 3'b010, 2'd0, 0, 0, 0, 0, 0);
      chk("sw_pc_cyc", pc_cyc, 4);
      run(7'b1100011, 3'b000, 2'd0, 1, 0, 0, 1, 0);
      chk("beq_t_pcsrc", {30'd0, pcsrc_seen}, 1);
      chk("beq_t_reg_we", {31'd0, reg_seen}, 0);
      run(7'b1100011, 3'b000, 2'd0, 0, 0, 0, 0, 0);
      chk("beq_nt_pcsrc", {30'd0, pcsrc_seen}, 0);
      run(7'b1101111, 3'b000, 2'd0, 0, 0, 0, 0, 0);
      run(7'b1100111, 3'b000, 2'd0, 0, 1, 0, 0, 0);
      chk("jalr_pcsrc", {30'd0, pcsrc_seen}, 2);
      run(7'b0110111, 3'b000, 2'd0, 0, 0, 0, 0, 0);
      run(7'b0010111, 3'b000, 2'd0, 0, 0, 0, 1, 0);
      run(7'b1110011, 3'b000, 2'd0, 0, 0, 0, 0, 0);
      chk("ecall_pc_cyc", pc_cyc, 3);
      chk("instret_after_mix", instret, 14);
      // lw misaligned
      run(7'b0000011, 3'b010, 2'd1, 0, 0, 0, 0, 0);
      chk("lw_mis_flag", {31'd0, misaligned}, 1);
      chk("lw_mis_state", {29'd0, state}, 5);
      chk("lw_mis_no_req", {31'd0, data_seen}, 0);
      do_reset();
      // unsupported opcode
      run(7'b0000000, 3'b000, 2'd0, 0, 0, 0, 0, 0);
      chk("op0_illegal", {31'd0, illegal}, 1);
      chk("op0_state", {29'd0, state}, 5);
      do_reset();
      run(7'b0000011, 3'b011, 2'd0, 0, 0, 0, 0, 0);
      chk("lf3_illegal", {31'd0, illegal}, 1);
      do_reset();
      run(7'b0100011, 3'b001, 2'd3, 0, 0, 0, 0, 0);
      chk("sh_mis_flag", {31'd0, misaligned}, 1);
      do_reset();
      run(7'b0010011, 3'b000, 2'd0, 0, 0, 0, 0, 0);
      // reset in the middle of a load data wait
      run(7'b0000011, 3'b010, 2'd0, 0, 0, 4, 0, 1);
      chk("rst_mid_instret", instret, 0);
      run(7'b0010011, 3'b000, 2'd0, 0, 0, 0, 0, 0);
      chk("post_rst_ir_cyc", ir_cyc, 1);
      chk("post_rst_instret", instret, 1);
      exp_valid = 0;
      tick();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
